// File: rtl/mem_pkg.sv
// Shared definitions for the data memory: FSM encoding, byte width and a
// width helper usable in parameter expressions.
package mem_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Address width for n words; never less than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((64'd1 << r) < 64'(n)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/mem_array.sv
// DEPTH x DATA_W storage with one byte-enabled write port and a registered
// read port; the storage itself has no reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/BYTE_W-1:0] wr_be,
  input  logic                     rd_en,
  input  logic                     rd_clr,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  localparam int unsigned NB = DATA_W / BYTE_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (wr_be[i]) mem_q[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Read register only moves on a load; rd_clr forces zero for bad addresses.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = rd_clr ? '0 : mem_q[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/data_memory.sv
// Load/store data memory: hardware clear after reset, valid/ready request and
// response handshake, byte-enable stores and out-of-range detection.
module data_memory
  import mem_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned DEPTH  = 256,
  localparam int unsigned ADDR_W = clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  input  logic [DATA_W/BYTE_W-1:0] req_be,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     addr_err,
  output logic                     init_busy
);

  localparam int unsigned NB = DATA_W / BYTE_W;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_W  = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clear_ptr_q, clear_ptr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              addr_err_q, addr_err_d;
  logic              init_busy_q, init_busy_d;

  logic              accept, in_range;
  logic              wr_en, rd_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NB-1:0]     wr_be;

  assign in_range  = {1'b0, req_addr} < DEPTH_L;
  assign req_ready = (state_q == ST_RUN) && !(rsp_valid_q && !rsp_ready);
  assign accept    = req_valid && req_ready;

  // Next state, clear sequencing, response tracking and write-port mux.
  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    rsp_valid_d = rsp_valid_q;
    addr_err_d  = 1'b0;
    init_busy_d = init_busy_q;
    wr_en       = 1'b0;
    wr_addr     = req_addr;
    wr_data     = req_wdata;
    wr_be       = req_be;
    rd_en       = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        wr_en       = 1'b1;
        wr_addr     = clear_ptr_q;
        wr_data     = '0;
        wr_be       = '1;
        clear_ptr_d = clear_ptr_q + ADDR_W'(1);
        if (clear_ptr_q == LAST_W) begin
          state_d     = ST_RUN;
          init_busy_d = 1'b0;
          clear_ptr_d = '0;
        end
      end
      ST_RUN: begin
        if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;
        if (accept) begin
          addr_err_d = !in_range;
          if (req_write) begin
            wr_en = in_range;
          end else begin
            rd_en       = 1'b1;
            rsp_valid_d = 1'b1;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      clear_ptr_q <= '0;
      rsp_valid_q <= 1'b0;
      addr_err_q  <= 1'b0;
      init_busy_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      addr_err_q  <= addr_err_d;
      init_busy_q <= init_busy_d;
    end
  end

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_be   (wr_be),
    .rd_en   (rd_en),
    .rd_clr  (!in_range),
    .rd_addr (req_addr),
    .rd_data (rsp_rdata)
  );

  assign rsp_valid = rsp_valid_q;
  assign addr_err  = addr_err_q;
  assign init_busy = init_busy_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: a 16-word instance for the main flows and a
// 12-word instance for out-of-range handling.
module tb_data_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        a_req_valid, a_req_ready, a_req_write;
  logic [3:0]  a_req_addr;
  logic [31:0] a_req_wdata;
  logic [3:0]  a_req_be;
  logic        a_rsp_valid, a_rsp_ready;
  logic [31:0] a_rsp_rdata;
  logic        a_addr_err, a_init_busy;

  logic        b_req_valid, b_req_ready, b_req_write;
  logic [3:0]  b_req_addr;
  logic [31:0] b_req_wdata;
  logic [3:0]  b_req_be;
  logic        b_rsp_valid, b_rsp_ready;
  logic [31:0] b_rsp_rdata;
  logic        b_addr_err, b_init_busy;

  int n_chk = 0;
  int n_err = 0;

  data_memory #(.DATA_W(32), .DEPTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
    .addr_err(a_addr_err), .init_busy(a_init_busy)
  );

  data_memory #(.DATA_W(32), .DEPTH(12)) u_dut12 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .addr_err(b_addr_err), .init_busy(b_init_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic a_store(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
    a_req_valid = 1'b1; a_req_write = 1'b1;
    a_req_addr = addr; a_req_wdata = data; a_req_be = be;
    @(negedge clk);
    a_req_valid = 1'b0;
  endtask

  task automatic a_load(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = addr;
    @(negedge clk);
    a_req_valid = 1'b0;
    check({tag, "_vld"}, 32'(a_rsp_valid), 32'd1);
    check(tag, a_rsp_rdata, exp);
  endtask

  task automatic b_store(input logic [3:0] addr, input logic [31:0] data);
    b_req_valid = 1'b1; b_req_write = 1'b1;
    b_req_addr = addr; b_req_wdata = data; b_req_be = 4'hF;
    @(negedge clk);
    b_req_valid = 1'b0;
  endtask

  task automatic b_load(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = addr;
    @(negedge clk);
    b_req_valid = 1'b0;
    check({tag, "_vld"}, 32'(b_rsp_valid), 32'd1);
    check(tag, b_rsp_rdata, exp);
  endtask

  // Counts cycles from reset release until the 16-word instance is ready.
  task automatic a_wait_clear(input string tag);
    int cnt;
    cnt = 0;
    while (!a_req_ready && cnt < 64) begin
      @(negedge clk);
      cnt++;
      if (cnt < 16) check({tag, "_busy"}, 32'(a_init_busy), 32'd1);
    end
    a_req_valid = 1'b0;
    check({tag, "_cycles"}, 32'(cnt), 32'd16);
    check({tag, "_idle"}, 32'(a_init_busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0;
    a_req_wdata = '0; a_req_be = '0; a_rsp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0;
    b_req_wdata = '0; b_req_be = '0; b_rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(a_req_ready), 32'd0);
    check("rst_rvld",  32'(a_rsp_valid), 32'd0);
    check("rst_rdata", a_rsp_rdata, 32'd0);
    check("rst_aerr",  32'(a_addr_err), 32'd0);
    check("rst_busy",  32'(a_init_busy), 32'd1);

    // A store held during the clear must be ignored.
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 4'd5;
    a_req_wdata = 32'hFFFF_FFFF; a_req_be = 4'hF;
    rst_n = 1'b1;
    a_wait_clear("clr1");
    check("b_ready", 32'(b_req_ready), 32'd1);
    a_load("ld15_clr", 4'd15, 32'h0);
    a_load("ld5_ign", 4'd5, 32'h0);

    a_store(4'd3, 32'hDEAD_BEEF, 4'hF);
    a_load("ld3_full", 4'd3, 32'hDEAD_BEEF);
    a_store(4'd3, 32'h0000_AA00, 4'b0010);
    a_load("ld3_be1", 4'd3, 32'hDEAD_AAEF);
    a_store(4'd3, 32'hFFFF_FFFF, 4'b0000);
    a_load("ld3_be0", 4'd3, 32'hDEAD_AAEF);
    a_store(4'd7, 32'h1122_3344, 4'hF);

    // Back-to-back loads keep rsp_valid high.
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 4'd3;
    @(negedge clk);
    a_req_addr = 4'd7;
    check("b2b_rd1", a_rsp_rdata, 32'hDEAD_AAEF);
    check("b2b_rdy", 32'(a_req_ready), 32'd1);
    @(negedge clk);
    a_req_valid = 1'b0;
    check("b2b_vld2", 32'(a_rsp_valid), 32'd1);
    check("b2b_rd2", a_rsp_rdata, 32'h1122_3344);
    @(negedge clk);
    check("b2b_drop", 32'(a_rsp_valid), 32'd0);
    check("b2b_hold", a_rsp_rdata, 32'h1122_3344);

    // Backpressure: response held while the next request waits.
    a_rsp_ready = 1'b0;
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 4'd3;
    @(negedge clk);
    a_req_addr = 4'd7;
    for (int i = 0; i < 3; i++) begin
      check("bp_vld", 32'(a_rsp_valid), 32'd1);
      check("bp_data", a_rsp_rdata, 32'hDEAD_AAEF);
      check("bp_nrdy", 32'(a_req_ready), 32'd0);
      @(negedge clk);
    end
    a_rsp_ready = 1'b1;
    @(negedge clk);
    a_req_valid = 1'b0;
    check("bp_next_vld", 32'(a_rsp_valid), 32'd1);
    check("bp_next_data", a_rsp_rdata, 32'h1122_3344);
    check("bp_rdy", 32'(a_req_ready), 32'd1);
    @(negedge clk);
    check("bp_done", 32'(a_rsp_valid), 32'd0);

    // Out-of-range on the 12-word instance.
    b_store(4'd11, 32'hCAFE_F00D);
    b_load("b_ld11", 4'd11, 32'hCAFE_F00D);
    check("b_inrange_err", 32'(b_addr_err), 32'd0);
    b_store(4'd13, 32'h1234_5678);
    check("b_st_err", 32'(b_addr_err), 32'd1);
    b_load("b_ld13", 4'd13, 32'h0);
    check("b_ld_err", 32'(b_addr_err), 32'd1);
    @(negedge clk);
    check("b_err_clr", 32'(b_addr_err), 32'd0);
    b_load("b_ld11_keep", 4'd11, 32'hCAFE_F00D);
    b_load("b_ld1_keep", 4'd1, 32'h0);

    // Reset while a response is pending.
    a_rsp_ready = 1'b0;
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 4'd3;
    @(negedge clk);
    a_req_valid = 1'b0;
    check("pre_rst_vld", 32'(a_rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_vld",   32'(a_rsp_valid), 32'd0);
    check("mid_rst_rdata", a_rsp_rdata, 32'd0);
    check("mid_rst_busy",  32'(a_init_busy), 32'd1);
    @(negedge clk);
    a_rsp_ready = 1'b1;
    rst_n = 1'b1;
    a_wait_clear("clr2");
    a_load("ld3_rezero", 4'd3, 32'h0);
    a_load("ld7_rezero", 4'd7, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
